// File: rtl/uart_pkg.sv
// Shared definitions for the UART frame path: FSM encoding and default frame marker.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PIXEL = 2'd1,
    ST_CHECK = 2'd2,
    ST_HOLD  = 2'd3
  } frame_state_t;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

endpackage

// File: rtl/uart_frame_assembler.sv
// Assembles SYNC + N_PIX pixel bytes + checksum from a UART byte stream into a
// pixel RAM, then holds the frame until the consumer acknowledges it.
module uart_frame_assembler
  import uart_pkg::*;
#(
  parameter int         N_PIX     = 784,
  parameter int         AW        = 10,
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
  input  logic          clk,
  input  logic          reset_b,
  input  logic          rx_done_tick,
  input  logic [7:0]    rx_byte,
  output logic          pix_we,
  output logic [AW-1:0] pix_addr,
  output logic [7:0]    pix_data,
  output logic          frame_valid,
  input  logic          frame_ack,
  output logic          chk_err,
  output logic          overrun
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(N_PIX - 1);

  frame_state_t  state, state_n;
  logic [AW-1:0] cnt, cnt_n;
  logic [7:0]    sum, sum_n;
  logic          pix_we_n;
  logic [AW-1:0] pix_addr_n;
  logic [7:0]    pix_data_n;
  logic          frame_valid_n;
  logic          chk_err_n;
  logic          overrun_n;

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      sum         <= '0;
      pix_we      <= 1'b0;
      pix_addr    <= '0;
      pix_data    <= '0;
      frame_valid <= 1'b0;
      chk_err     <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      sum         <= sum_n;
      pix_we      <= pix_we_n;
      pix_addr    <= pix_addr_n;
      pix_data    <= pix_data_n;
      frame_valid <= frame_valid_n;
      chk_err     <= chk_err_n;
      overrun     <= overrun_n;
    end
  end

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    sum_n      = sum;
    pix_we_n   = 1'b0;
    pix_addr_n = pix_addr;
    pix_data_n = pix_data;
    chk_err_n  = 1'b0;
    overrun_n  = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (rx_done_tick && (rx_byte == SYNC_BYTE)) begin
          cnt_n   = '0;
          sum_n   = '0;
          state_n = ST_PIXEL;
        end
      end
      ST_PIXEL: begin
        if (rx_done_tick) begin
          pix_we_n   = 1'b1;
          pix_addr_n = cnt;
          pix_data_n = rx_byte;
          sum_n      = sum + rx_byte;
          // Wrap the counter on the last pixel so it never reaches N_PIX.
          if (cnt == LAST_ADDR) begin
            cnt_n   = '0;
            state_n = ST_CHECK;
          end else begin
            cnt_n = cnt + AW'(1);
          end
        end
      end
      ST_CHECK: begin
        if (rx_done_tick) begin
          if (rx_byte == sum) begin
            state_n = ST_HOLD;
          end else begin
            chk_err_n = 1'b1;
            state_n   = ST_IDLE;
          end
        end
      end
      ST_HOLD: begin
        // The RAM still belongs to the consumer, so incoming bytes are lost.
        if (rx_done_tick) overrun_n = 1'b1;
        if (frame_ack)    state_n   = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase

    frame_valid_n = (state_n == ST_HOLD);
  end

endmodule
